instr_fetch_buffer: RTL
=======================

Name: instr_fetch_buffer

Overview:
- Small instruction FIFO between the instruction-fetch port and the decode stage that hosts the immediate generation unit.
- Decouples fetch latency from decode stalls.
- Carries each instruction word together with its fetch address (PC); decode and immediate generation need the PC for PC-relative offsets.
- Presents the head entry to decode with a valid/ready handshake and supports a single-cycle flush on branch redirect.

Parameters:
- WORD_LENGTH, 24: instruction and PC width in bits.
- DEPTH, 4: number of entries. Must be a power of two, >= 2.
- NOP_INSTR, 24'h000000: value driven on outInstr while the buffer presents no valid entry.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active high.
- flush  in  1  synchronous discard of all entries, taken at the next rising edge.
- inValid  in  1  fetch offers an instruction this cycle.
- inReady  out  1  buffer accepts an instruction this cycle.
- inInstr  in  WORD_LENGTH  fetched instruction word.
- inPc  in  WORD_LENGTH  fetch address of inInstr.
- outValid  out  1  head entry is valid for decode.
- outReady  in  1  decode consumes the head entry this cycle.
- outInstr  out  WORD_LENGTH  head instruction word (feeds decode and immediate generation).
- outPc  out  WORD_LENGTH  head PC.
- count  out  $clog2(DEPTH)+1  current number of stored entries.

Behaviour:
- Reset (async, rst=1): rdPtr=0, wrPtr=0, count=0, outValid=0, inReady=1, outInstr=NOP_INSTR, outPc=0. Storage contents are don't-care. Reset asserted mid-transfer discards everything immediately, without waiting for a clock edge.
- Pointers are $clog2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
  - empty when rdPtr==wrPtr.
  - full when the index bits are equal and the MSBs differ.
  - Pointers wrap modulo 2*DEPTH; storage index is ptr[low bits].
- push = inValid & inReady. pop = outValid & outReady.
- inReady = !full. There is no combinational path from outReady to inReady, so a full buffer refuses a push even if a pop occurs in the same cycle.
- push: mem[wrIdx] <= {inInstr, inPc}; wrPtr+1.
- pop: rdPtr+1.
- Simultaneous push and pop when neither full nor empty: both happen and count is unchanged.
- outValid = !empty. outInstr/outPc are read combinationally from mem[rdIdx] when valid, else NOP_INSTR / 0.
- Latency (no bypass): an instruction accepted at edge N is visible on the outputs after edge N and is poppable in cycle N+1.
- flush=1 at an edge:
  - rdPtr, wrPtr and count are cleared.
  - Any push or pop in that same cycle is ignored, and the pushed word is dropped.
  - The following cycle outValid=0 and inReady=1.
- Decode stall: outReady=0 holds the head entry and its outputs stable indefinitely.
- count = wrPtr - rdPtr (modulo arithmetic); range 0..DEPTH.
- Illegal input: inValid with X data is stored as-is; the buffer checks nothing.

Optional Feature:
- Macro: FETCH_BUF_BYPASS_EN.
- With the macro defined, when the buffer is empty and flush=0:
  - outValid = inValid, outInstr = inInstr, outPc = inPc (combinational pass-through).
  - If outReady=1 in that cycle, the word is consumed directly and not written; pointers and count are unchanged.
  - If outReady=0, the word is written normally (push).
  - inReady stays !full in all cases.
- Without the macro: no pass-through; minimum fetch-to-decode latency is one cycle, and outValid=0 whenever empty.

Test Plan:
1. Reset then idle: rst pulse mid-cycle -> outputs clear without a clock edge; outValid=0, inReady=1, count=0, outInstr=24'h000000.
2. Fill and drain in order: push instr 24'h100001..24'h100004 with PCs 24'h000100..24'h00010C while outReady=0:
   - after 4 pushes, count=4 and inReady=0; a 5th offer (24'h100005) is not accepted.
   - set outReady=1 -> outputs 24'h100001..24'h100004 in order with matching PCs, then outValid=0.
3. Wrap-around with concurrent traffic: run 10 consecutive cycles with inValid=1 and outReady=1 from count=2 -> count stays 2, the output sequence is strictly FIFO ordered, and pointers wrap past index 3 correctly.
4. Flush: with 3 entries stored, assert flush together with inValid=1 (24'hABCDEF) and outReady=1 -> next cycle count=0 and outValid=0; 24'hABCDEF never appears on outInstr.
5. Stall hold: with head 24'h123456/PC 24'h000200, hold outReady=0 for 5 cycles -> outInstr/outPc unchanged and count unchanged.
6. FETCH_BUF_BYPASS_EN build: when empty, inValid=1, inInstr=24'h0F0F0F, outReady=1 -> same cycle outValid=1 and outInstr=24'h0F0F0F, count stays 0. Repeat with outReady=0 -> count=1 after the edge.

Source files
------------

// File: rtl/instr_fetch_buffer_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_buffer_if
//
// Purpose: bundles the fetch-side and decode-side handshakes of the
// instruction fetch buffer.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// when valid and ready are both high in that cycle. The offering side holds
// its word stable while valid is high and ready is low.
//
// Signals:
//   inValid  - fetch offers an instruction this cycle
//   inReady  - buffer accepts an instruction this cycle
//   inInstr  - fetched instruction word
//   inPc     - fetch address of inInstr
//   outValid - head entry is valid for decode
//   outReady - decode consumes the head entry this cycle
//   outInstr - head instruction word
//   outPc    - head PC
//
// Modports:
//   master - the environment around the buffer (fetch unit + decode stage)
//   slave  - the buffer itself
// -----------------------------------------------------------------------------
interface instr_fetch_buffer_if #(
  parameter int WORD_LENGTH = 24
);
  logic                   inValid;
  logic                   inReady;
  logic [WORD_LENGTH-1:0] inInstr;
  logic [WORD_LENGTH-1:0] inPc;
  logic                   outValid;
  logic                   outReady;
  logic [WORD_LENGTH-1:0] outInstr;
  logic [WORD_LENGTH-1:0] outPc;

  modport master (
    output inValid, inInstr, inPc, outReady,
    input  inReady, outValid, outInstr, outPc
  );

  modport slave (
    input  inValid, inInstr, inPc, outReady,
    output inReady, outValid, outInstr, outPc
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_fetch_buffer
//
// Purpose: small instruction FIFO between instruction fetch and decode.
// Each entry holds an instruction word and its fetch PC. The head entry is
// presented to decode combinationally; a flush discards all entries at the
// next rising edge.
//
// Optional feature (macro FETCH_BUF_BYPASS_EN): when the buffer is empty and
// no flush is requested, the incoming word is passed straight through to the
// decode outputs. If decode takes it in the same cycle it is never written.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - asynchronous reset, active high
//   flush  - synchronous discard of all entries
//   bus    - fetch/decode handshakes (instr_fetch_buffer_if.slave)
//   count  - number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module instr_fetch_buffer #(
  parameter int                     WORD_LENGTH = 24,
  parameter int                     DEPTH       = 4,
  parameter logic [WORD_LENGTH-1:0] NOP_INSTR   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  instr_fetch_buffer_if.slave      bus,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra MSB so full and empty can be told apart.
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [2*WORD_LENGTH-1:0]   mem_q [DEPTH];

  logic [AW-1:0]              rd_idx;
  logic [AW-1:0]              wr_idx;
  logic                       empty;
  logic                       full;
  logic                       push;
  logic                       pop;
  logic                       bypass_take;

  logic                       out_valid;
  logic [WORD_LENGTH-1:0]     out_instr;
  logic [WORD_LENGTH-1:0]     out_pc;

  assign rd_idx = rd_ptr_q[AW-1:0];
  assign wr_idx = wr_ptr_q[AW-1:0];
  assign empty  = (rd_ptr_q == wr_ptr_q);
  assign full   = (rd_idx == wr_idx) && (rd_ptr_q[AW] != wr_ptr_q[AW]);
  assign count  = wr_ptr_q - rd_ptr_q;

  // inReady depends only on stored state, so a full buffer refuses a push
  // even when decode pops in the same cycle.
  assign bus.inReady = !full;

  // Head presentation (and optional pass-through when empty).
  always_comb begin
    out_valid   = !empty;
    out_instr   = NOP_INSTR;
    out_pc      = '0;
    bypass_take = 1'b0;
    if (!empty) begin
      {out_instr, out_pc} = mem_q[rd_idx];
    end
`ifdef FETCH_BUF_BYPASS_EN
    else if (!flush && bus.inValid) begin
      out_valid   = 1'b1;
      out_instr   = bus.inInstr;
      out_pc      = bus.inPc;
      // Decode consumes the word directly; it must not also be stored.
      bypass_take = bus.outReady;
    end
`endif
  end

  assign bus.outValid = out_valid;
  assign bus.outInstr = out_instr;
  assign bus.outPc    = out_pc;

  // Pop only ever removes a stored entry; a bypassed word is never stored.
  assign push = bus.inValid && !full && !bypass_take;
  assign pop  = !empty && bus.outReady;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      // Flush wins over any push/pop in the same cycle.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset: contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_idx] <= {bus.inInstr, bus.inPc};
    end
  end

endmodule
